// File: rtl/popcount22_vecgen.sv
// rtl/popcount22_vecgen.sv - enumerates every N-bit vector of a given weight (Gosper order), optionally sweeping weights up to N
module popcount22_vecgen #(
    parameter int N  = 22,
    parameter int KW = 5,
    parameter int IW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_in,
    input  logic          sweep,
    input  logic          abort,
    output logic [N-1:0]  vec_out,
    output logic [KW-1:0] ref_count,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic          vec_last,
    output logic [IW-1:0] vec_index,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [KW-1:0] NK = KW'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  vec_r, vec_n;
    logic [KW-1:0] ref_r, ref_n;
    logic          valid_r, valid_n;
    logic [IW-1:0] idx_r, idx_n;
    logic          err_r, err_n;
    logic          sweep_r, sweep_n;
    logic          final_k;

    function automatic logic [N-1:0] low_ones(input logic [KW-1:0] k);
        low_ones = ~({N{1'b1}} << k);
    endfunction

    function automatic logic [N-1:0] high_ones(input logic [KW-1:0] k);
        high_ones = ~({N{1'b1}} >> k);
    endfunction

    // Smallest larger value with the same number of ones.
    function automatic logic [N-1:0] gosper_next(input logic [N-1:0] x);
        logic [N-1:0] c;
        logic [N-1:0] r;
        logic [N-1:0] s;
        int           tz;
        c  = x & (-x);
        r  = x + c;
        tz = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (x[i]) tz = i;
        end
        s = (x ^ r) >> 2;
        gosper_next = r | (s >> tz);
    endfunction

    assign final_k   = (vec_r == high_ones(ref_r));
    assign vec_out   = vec_r;
    assign ref_count = ref_r;
    assign vec_valid = valid_r;
    assign vec_index = idx_r;
    assign err       = err_r;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    // In sweep mode only the all-ones vector closes the run.
    assign vec_last  = valid_r && (sweep_r ? (ref_r == NK) : final_k);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            vec_r   <= '0;
            ref_r   <= '0;
            valid_r <= 1'b0;
            idx_r   <= '0;
            err_r   <= 1'b0;
            sweep_r <= 1'b0;
        end else begin
            state   <= state_n;
            vec_r   <= vec_n;
            ref_r   <= ref_n;
            valid_r <= valid_n;
            idx_r   <= idx_n;
            err_r   <= err_n;
            sweep_r <= sweep_n;
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = vec_r;
        ref_n   = ref_r;
        valid_n = valid_r;
        idx_n   = idx_r;
        err_n   = err_r;
        sweep_n = sweep_r;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (k_in > NK) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = S_RUN;
                        vec_n   = low_ones(k_in);
                        ref_n   = k_in;
                        valid_n = 1'b1;
                        idx_n   = '0;
                        err_n   = 1'b0;
                        sweep_n = sweep;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                end else if (valid_r && vec_ready) begin
                    idx_n = idx_r + IW'(1);
                    if (vec_last) begin
                        state_n = S_DONE;
                        valid_n = 1'b0;
                    end else if (final_k) begin
                        vec_n = low_ones(ref_r + KW'(1));
                        ref_n = ref_r + KW'(1);
                    end else begin
                        vec_n = gosper_next(vec_r);
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule
